// File: rtl/ram_arbiter.sv
// Three-way arbiter for one single-port synchronous RAM: video > (promoted loader) > CPU > loader.
// One access in flight; each access occupies IDLE-grant, RAM_LAT ACCESS cycles and one DONE cycle.
module ram_arbiter #(
  parameter int AW      = 17,
  parameter int RAM_LAT = 2,
  parameter int STARVE  = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vidReq,
  input  logic [AW-1:0] vidA,
  output logic [7:0]    vidQ,
  output logic          vidAck,
  input  logic          cpuReq,
  input  logic          cpuWr,
  input  logic [AW-1:0] cpuA,
  input  logic [7:0]    cpuD,
  output logic [7:0]    cpuQ,
  output logic          cpuAck,
  input  logic          ldrReq,
  input  logic [AW-1:0] ldrA,
  input  logic [7:0]    ldrD,
  output logic          ldrAck,
  output logic [AW-1:0] ramA,
  output logic [7:0]    ramD,
  output logic          ramWe,
  input  logic [7:0]    ramQ,
  output logic          busy
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [1:0] O_NONE = 2'd0;
  localparam logic [1:0] O_VID  = 2'd1;
  localparam logic [1:0] O_CPU  = 2'd2;
  localparam logic [1:0] O_LDR  = 2'd3;

  localparam int         SW     = $clog2(STARVE + 1);
  localparam logic [2:0] LAT_M1 = 3'(RAM_LAT - 1);

  logic [1:0]    r_state;
  logic [1:0]    r_owner;
  logic          r_wr;
  logic [2:0]    r_cnt;
  logic [SW-1:0] r_starve;
  logic          w_promote;
  logic [1:0]    w_grant;

  assign busy      = (r_state != S_IDLE);
  assign w_promote = (r_starve == SW'(STARVE));

  always_comb begin
    w_grant = O_NONE;
    if (vidReq)                  w_grant = O_VID;
    else if (ldrReq && w_promote) w_grant = O_LDR;
    else if (cpuReq)             w_grant = O_CPU;
    else if (ldrReq)             w_grant = O_LDR;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_owner  <= O_NONE;
      r_wr     <= 1'b0;
      r_cnt    <= '0;
      r_starve <= '0;
      ramA     <= '0;
      ramD     <= '0;
      ramWe    <= 1'b0;
      vidQ     <= '0;
      cpuQ     <= '0;
      vidAck   <= 1'b0;
      cpuAck   <= 1'b0;
      ldrAck   <= 1'b0;
    end else begin
      vidAck <= 1'b0;
      cpuAck <= 1'b0;
      ldrAck <= 1'b0;
      ramWe  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant != O_NONE) begin
            r_owner <= w_grant;
            r_cnt   <= LAT_M1;
            r_state <= S_ACCESS;
            case (w_grant)
              O_VID: begin
                ramA <= vidA;
                r_wr <= 1'b0;
              end
              O_CPU: begin
                ramA <= cpuA;
                r_wr <= cpuWr;
                if (cpuWr) begin
                  ramD  <= cpuD;
                  ramWe <= 1'b1;
                end
                // Loader lost this grant to the CPU: count toward promotion
                if (ldrReq && !w_promote) r_starve <= r_starve + SW'(1);
              end
              default: begin
                ramA     <= ldrA;
                ramD     <= ldrD;
                ramWe    <= 1'b1;
                r_wr     <= 1'b1;
                r_starve <= '0;
              end
            endcase
          end
        end
        S_ACCESS: begin
          if (r_cnt == 3'd0) r_state <= S_DONE;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        S_DONE: begin
          case (r_owner)
            O_VID: begin
              vidAck <= 1'b1;
              vidQ   <= ramQ;
            end
            O_CPU: begin
              cpuAck <= 1'b1;
              if (!r_wr) cpuQ <= ramQ;
            end
            O_LDR:   ldrAck <= 1'b1;
            default: ;
          endcase
          r_owner <= O_NONE;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 2-cycle-latency RAM model.
module tb_ram_arbiter;
  localparam int AW  = 17;
  localparam int LAT = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          vidReq = 1'b0, cpuReq = 1'b0, cpuWr = 1'b0, ldrReq = 1'b0;
  logic [AW-1:0] vidA = '0, cpuA = '0, ldrA = '0;
  logic [7:0]    cpuD = '0, ldrD = '0;
  logic [7:0]    vidQ, cpuQ, ramD, ramQ;
  logic          vidAck, cpuAck, ldrAck, ramWe, busy;
  logic [AW-1:0] ramA;

  int total = 0;
  int bad   = 0;
  string seq;
  int nwe, tv, tc, tl;

  always #5 clock = ~clock;

  ram_arbiter #(.AW(AW), .RAM_LAT(LAT), .STARVE(8)) dut (
    .clock(clock), .reset(reset),
    .vidReq(vidReq), .vidA(vidA), .vidQ(vidQ), .vidAck(vidAck),
    .cpuReq(cpuReq), .cpuWr(cpuWr), .cpuA(cpuA), .cpuD(cpuD), .cpuQ(cpuQ), .cpuAck(cpuAck),
    .ldrReq(ldrReq), .ldrA(ldrA), .ldrD(ldrD), .ldrAck(ldrAck),
    .ramA(ramA), .ramD(ramD), .ramWe(ramWe), .ramQ(ramQ), .busy(busy)
  );

  // RAM model: address seen in cycle N gives data on ramQ in cycle N+2
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] q1;
  always @(posedge clock) begin
    if (ramWe) mem[ramA] <= ramD;
    q1   <= mem[ramA];
    ramQ <= q1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chks(input string tag, input string obs, input string exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
    end
  endtask

  // Acts as all three requesters for ncyc cycles; drops each req on its ack.
  task automatic watch(input int ncyc, input int cpu_n, input int vid_at);
    int ncpu;
    ncpu = 0; seq = ""; nwe = 0; tv = -1; tc = -1; tl = -1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clock);
      if (ramWe) nwe++;
      if (vidAck) begin seq = {seq, "V"}; if (tv < 0) tv = c; vidReq = 1'b0; end
      if (ldrAck) begin seq = {seq, "L"}; if (tl < 0) tl = c; ldrReq = 1'b0; end
      if (cpuAck) begin
        seq = {seq, "C"}; if (tc < 0) tc = c; ncpu++;
        if (ncpu >= cpu_n) cpuReq = 1'b0;
        if (ncpu == vid_at) vidReq = 1'b1;
      end
    end
  endtask

  initial begin
    mem[17'h04000] = 8'h5A;
    mem[17'h00100] = 8'h33;
    mem[17'h00200] = 8'h11;

    // reset state
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_we", ramWe, 0);
    chk("rst_acks", {vidAck, cpuAck, ldrAck}, 0);
    chk("rst_ramA", ramA, 0);
    chk("rst_ramD", ramD, 0);
    chk("rst_q", {vidQ, cpuQ}, 0);
    reset = 1'b1;
    @(negedge clock);

    // single CPU read; CPU inputs change mid-access
    cpuA = 17'h04000; cpuWr = 1'b0; cpuReq = 1'b1;
    @(negedge clock);
    chk("rd_c1_ramA", ramA, 17'h04000);
    chk("rd_c1_busy", busy, 1);
    chk("rd_c1_we", ramWe, 0);
    cpuA = 17'h00100; cpuWr = 1'b1; cpuD = 8'hEE;
    @(negedge clock);
    chk("rd_c2_busy", busy, 1);
    chk("rd_c2_we", ramWe, 0);
    @(negedge clock);
    chk("rd_c3_busy", busy, 1);
    chk("rd_c3_ack", cpuAck, 0);
    @(negedge clock);
    chk("rd_c4_ack", cpuAck, 1);
    chk("rd_c4_q", cpuQ, 8'h5A);
    chk("rd_c4_busy", busy, 0);
    chk("rd_c4_ramA", ramA, 17'h04000);
    cpuReq = 1'b0;
    @(negedge clock);
    chk("rd_c5_ack", cpuAck, 0);
    chk("rd_c5_busy", busy, 0);

    // CPU write then read-back
    cpuA = 17'h1C000; cpuD = 8'hA7; cpuWr = 1'b1; cpuReq = 1'b1;
    watch(6, 1, -1);
    chk("wr_nwe", nwe, 1);
    chk("wr_ack_cyc", tc, 4);
    chk("wr_ramD", ramD, 8'hA7);
    cpuWr = 1'b0; cpuD = 8'h00; cpuReq = 1'b1;
    watch(6, 1, -1);
    chk("rb_ack_cyc", tc, 4);
    chk("rb_q", cpuQ, 8'hA7);
    chk("rb_nwe", nwe, 0);

    // video and CPU in the same cycle
    vidA = 17'h00100; vidReq = 1'b1;
    cpuA = 17'h04000; cpuWr = 1'b0; cpuReq = 1'b1;
    watch(10, 1, -1);
    chks("vc_order", seq, "VC");
    chk("vc_vid_cyc", tv, 4);
    chk("vc_cpu_cyc", tc, 8);
    chk("vc_nwe", nwe, 0);
    chk("vc_vidQ", vidQ, 8'h33);
    chk("vc_cpuQ", cpuQ, 8'h5A);

    // starvation: 8 CPU grants, then the loader, then the CPU again
    ldrA = 17'h00300; ldrD = 8'h6C; ldrReq = 1'b1;
    cpuA = 17'h00300; cpuWr = 1'b0; cpuReq = 1'b1;
    watch(44, 9, -1);
    chks("st_order", seq, "CCCCCCCCLC");
    chk("st_ldr_cyc", tl, 36);
    chk("st_nwe", nwe, 1);
    chk("st_coherent", cpuQ, 8'h6C);

    // counter cleared: CPU first again; video preempts the promoted loader
    ldrA = 17'h00400; ldrD = 8'h2B; ldrReq = 1'b1;
    cpuA = 17'h04000; cpuReq = 1'b1;
    vidA = 17'h00100;
    watch(48, 9, 8);
    chks("pv_order", seq, "CCCCCCCCVLC");
    chk("pv_vid_cyc", tv, 36);
    chk("pv_ldr_cyc", tl, 40);
    chk("pv_cpu_first", tc, 4);

    // reset during the write cycle of an access
    repeat (2) @(negedge clock);
    cpuA = 17'h00200; cpuD = 8'h99; cpuWr = 1'b1; cpuReq = 1'b1;
    @(negedge clock);
    chk("ra_we_before", ramWe, 1);
    reset = 1'b0;
    cpuReq = 1'b0;
    #1;
    chk("ra_we_after", ramWe, 0);
    chk("ra_busy", busy, 0);
    chk("ra_acks", {vidAck, cpuAck, ldrAck}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    watch(8, 1, -1);
    chks("ra_no_ack", seq, "");
    chk("ra_idle", busy, 0);
    cpuA = 17'h00200; cpuWr = 1'b0; cpuReq = 1'b1;
    watch(6, 1, -1);
    chk("ra_not_written", cpuQ, 8'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port synchronous RAM between three requesters: video fetch, Z80 CPU and the tape/snapshot loader.
- Sits between the memory block's RAM array and its clients.
- Video has fixed top priority. CPU has priority over the loader, except a starvation guard periodically promotes the loader above the CPU.
- One access in flight at a time; every access has a fixed, parameterised latency.

Parameters:
AW, 17, RAM address width (128K).
RAM_LAT, 2, clock cycles from address presentation to valid ramQ (1..7).
STARVE, 8, consecutive loader-pending grants lost to the CPU before the loader is promoted.

Ports:
clock  input  1  system clock (56 MHz)
reset  input  1  asynchronous, active-low reset
vidReq  input  1  video read request, level, held until vidAck
vidA  input  AW  video address
vidQ  output  8  video read data, valid from vidAck, held until next vidAck
vidAck  output  1  one-cycle completion pulse
cpuReq  input  1  CPU request, level, held until cpuAck
cpuWr  input  1  1 = write, 0 = read; sampled at grant
cpuA  input  AW  CPU address
cpuD  input  8  CPU write data
cpuQ  output  8  CPU read data, held until next CPU read ack
cpuAck  output  1  one-cycle completion pulse
ldrReq  input  1  loader write request, level, held until ldrAck
ldrA  input  AW  loader address
ldrD  input  8  loader write data
ldrAck  output  1  one-cycle completion pulse
ramA  output  AW  RAM address
ramD  output  8  RAM write data
ramWe  output  1  RAM write enable, one cycle per write
ramQ  input  8  RAM read data
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async, reset=0):
  - state IDLE, all acks 0, ramWe 0.
  - ramA, ramD, vidQ and cpuQ all 0.
  - Starvation counter 0, grant owner none.
  - Reset mid-access abandons the access; no ack is issued and no write is retried.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Requests are sampled on each clock edge.
  - Winner: vidReq; else ldrReq if promoted; else cpuReq; else ldrReq.
  - On a grant: register owner and address to ramA; load the latency counter with RAM_LAT-1; go to ACCESS.
  - For a write grant: ramD <= data and ramWe = 1 for exactly the first ACCESS cycle. Loader accesses are always writes; video accesses are always reads.
- ACCESS: counter decrements each cycle; at 0 go to DONE.
- DONE:
  - Pulse the owner's ack for one cycle.
  - For reads, capture ramQ into vidQ or cpuQ on the same edge the ack rises.
  - Return to IDLE.
- Timing: request-to-ack latency is RAM_LAT+2 cycles from the IDLE sampling edge. Minimum grant spacing is RAM_LAT+2 cycles.
- Requester contract: req is deasserted on the edge where its ack is high. The IDLE cycle after DONE therefore never sees a stale request from the same owner.
- ramA and ramD hold their last value between accesses. busy = (state != IDLE).
- Starvation guard:
  - Counter increments (saturating at STARVE) on each grant to the CPU while ldrReq is high.
  - Counter clears on any loader grant.
  - Promotion is active when counter == STARVE.
  - Video still preempts a promoted loader; the counter is not cleared by video grants.
- Simultaneous events:
  - All three requests in the same IDLE cycle: video wins; the others wait and are re-evaluated at the next IDLE.
  - cpuWr, cpuA and cpuD changing while a CPU access is in ACCESS have no effect.
- Write-read coherence: a CPU read granted after a loader write to the same address returns the written byte (accesses are strictly serialised).

Test Plan:
- Single CPU read with RAM_LAT=2, ramQ model returns 0x5A at 0x04000: cpuReq at cycle 0 -> ramA=0x04000 at cycle 1, cpuAck and cpuQ=0x5A at cycle 4; busy high cycles 1-3.
- CPU write 0xA7 to 0x1C000: exactly one ramWe pulse with ramD=0xA7, cpuAck at +4 cycles; a following CPU read of 0x1C000 returns 0xA7.
- vidReq and cpuReq asserted in the same cycle: vidAck precedes cpuAck by exactly 4 cycles; no overlapping ramWe.
- ldrReq held while cpuReq is re-asserted after every ack (STARVE=8): 8 CPU grants, then 1 loader grant, then counter back to 0 and the CPU resumes.
- Video request during a promoted loader wait: video still granted first; the loader follows the video ack before any CPU grant.
- reset pulled low in ACCESS of a write: ramWe and acks go to 0 immediately; after release, state is IDLE and no ack is issued for the aborted access.
